// File: rtl/mem_wb_multi.sv
// MEM/WB pipeline register for the multi-issue core: LANES register-write lanes plus a shared HI/LO write.
// Optional retire counter is enabled by defining MEM_WB_PERF_EN; otherwise retired is tied to 0.

module mem_wb_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              valid,
  input  logic [ADDR_W-1:0] wd,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wreg,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_wd,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_wreg
);
  // clear covers both flush and bubble; it outranks load so flush wins over a concurrent load
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wb_valid <= 1'b0;
      wb_wd    <= '0;
      wb_wdata <= '0;
      wb_wreg  <= 1'b0;
    end else if (load) begin
      wb_valid <= valid;
      wb_wd    <= wd;
      wb_wdata <= wdata;
      wb_wreg  <= wreg;
    end
  end
endmodule

module mem_wb_multi #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_mem,
  input  logic                    stall_wb,
  input  logic                    flush,
  input  logic [LANES-1:0]        mem_valid,
  input  logic [LANES*ADDR_W-1:0] mem_wd,
  input  logic [LANES*DATA_W-1:0] mem_wdata,
  input  logic [LANES-1:0]        mem_wreg,
  input  logic [DATA_W-1:0]       mem_hi,
  input  logic [DATA_W-1:0]       mem_lo,
  input  logic                    mem_whilo,
  output logic [LANES-1:0]        wb_valid,
  output logic [LANES*ADDR_W-1:0] wb_wd,
  output logic [LANES*DATA_W-1:0] wb_wdata,
  output logic [LANES-1:0]        wb_wreg,
  output logic [DATA_W-1:0]       wb_hi,
  output logic [DATA_W-1:0]       wb_lo,
  output logic                    wb_whilo,
  output logic [CNT_W-1:0]        retired
);
  logic clear, load;
  logic [LANES-1:0][ADDR_W-1:0] wd_a, wb_wd_a;
  logic [LANES-1:0][DATA_W-1:0] wdata_a, wb_wdata_a;
  logic [LANES-1:0] qual, wreg_res;

  assign clear   = flush | (stall_mem & ~stall_wb);
  assign load    = ~stall_mem;
  assign wd_a    = mem_wd;
  assign wdata_a = mem_wdata;
  assign wb_wd    = wb_wd_a;
  assign wb_wdata = wb_wdata_a;

  // $zero writes and invalid lanes never enable; a program-later lane steals a shared address
  always_comb begin
    wreg_res = '0;
    for (int i = 0; i < LANES; i++)
      qual[i] = mem_wreg[i] & mem_valid[i] & (wd_a[i] != '0);
    for (int i = 0; i < LANES; i++) begin
      wreg_res[i] = qual[i];
      for (int j = i + 1; j < LANES; j++)
        if (qual[j] && (wd_a[j] == wd_a[i])) wreg_res[i] = 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      mem_wb_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .clear    (clear),
        .valid    (mem_valid[g]),
        .wd       (wd_a[g]),
        .wdata    (wdata_a[g]),
        .wreg     (wreg_res[g]),
        .wb_valid (wb_valid[g]),
        .wb_wd    (wb_wd_a[g]),
        .wb_wdata (wb_wdata_a[g]),
        .wb_wreg  (wb_wreg[g])
      );
    end
  endgenerate

  // HI/LO rides with lane 0
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wb_hi    <= '0;
      wb_lo    <= '0;
      wb_whilo <= 1'b0;
    end else if (load) begin
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
      wb_whilo <= mem_whilo & mem_valid[0];
    end
  end

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + CNT_W'(mem_valid[i]);
  end

  // counts only real load edges; wraps without saturation
  always_ff @(posedge clk) begin
    if (rst)                retired <= '0;
    else if (load && !flush) retired <= retired + pop;
  end
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_mem_wb_multi.sv
// Scoreboard bench for mem_wb_multi (LANES=2, CNT_W=4): directed vectors, hand-computed expectations.
`timescale 1ns/1ps

module tb_mem_wb_multi;
  typedef struct packed {
    logic [1:0]  valid;
    logic [9:0]  wd;
    logic [63:0] wdata;
    logic [1:0]  wreg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
  } obs_t;

  typedef struct packed {
    obs_t       o;
    logic [3:0] ret;
  } exp_t;

  logic clk = 0, rst = 0, stall_mem = 0, stall_wb = 0, flush = 0;
  logic [1:0]  mem_valid = '0, mem_wreg = '0;
  logic [9:0]  mem_wd = '0;
  logic [63:0] mem_wdata = '0;
  logic [31:0] mem_hi = '0, mem_lo = '0;
  logic        mem_whilo = 0;
  logic [1:0]  wb_valid, wb_wreg;
  logic [9:0]  wb_wd;
  logic [63:0] wb_wdata;
  logic [31:0] wb_hi, wb_lo;
  logic        wb_whilo;
  logic [3:0]  retired;

  exp_t       sb[$];
  int         n_vec = 0, n_bad = 0;
  logic [3:0] ret_m = 0;

  mem_wb_multi #(.LANES(2), .DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] v, input logic [4:0] wd1, input logic [4:0] wd0,
                              input logic [31:0] d1, input logic [31:0] d0, input logic [1:0] wr,
                              input logic [31:0] hi, input logic [31:0] lo, input logic wh);
    obs_t r;
    r.valid = v; r.wd = {wd1, wd0}; r.wdata = {d1, d0}; r.wreg = wr;
    r.hi = hi; r.lo = lo; r.whilo = wh;
    return r;
  endfunction

  // drive one cycle of inputs and queue the state expected right after the next edge
  task automatic step(input logic r, input logic sm, input logic sw, input logic fl,
                      input obs_t in, input obs_t ex, input int ret_add);
    exp_t e;
    @(negedge clk);
    rst = r; stall_mem = sm; stall_wb = sw; flush = fl;
    mem_valid = in.valid; mem_wd = in.wd; mem_wdata = in.wdata; mem_wreg = in.wreg;
    mem_hi = in.hi; mem_lo = in.lo; mem_whilo = in.whilo;
    if (r) ret_m = 4'd0;
    else   ret_m = ret_m + 4'(ret_add);
    e.o = ex;
`ifdef MEM_WB_PERF_EN
    e.ret = ret_m;
`else
    e.ret = 4'd0;
`endif
    sb.push_back(e);
  endtask

  // monitor: the register presents a new value every edge, so compare each cycle an entry is queued
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        obs_t a;
        e = sb.pop_front();
        a = '{valid: wb_valid, wd: wb_wd, wdata: wb_wdata, wreg: wb_wreg,
              hi: wb_hi, lo: wb_lo, whilo: wb_whilo};
        n_vec++;
        if (a !== e.o) begin
          n_bad++;
          $display("FAIL wb_outputs: got %h expected %h", a, e.o);
        end
        n_vec++;
        if (retired !== e.ret) begin
          n_bad++;
          $display("FAIL retired: got %0d expected %0d", retired, e.ret);
        end
      end
    end
  end

  obs_t Z, A, Ae, C, Ce, D, De, E, Ee, F, Fe, H, Ed, N, Ne;

  initial begin
    Z  = '0;
    A  = mk(2'b11, 5'd7, 5'd3, 32'h22, 32'h11, 2'b11, 32'h1, 32'h2, 1'b0);
    Ae = A;
    C  = mk(2'b11, 5'd5, 5'd5, 32'h44, 32'h33, 2'b11, 32'hAA, 32'hBB, 1'b1);
    Ce = mk(2'b11, 5'd5, 5'd5, 32'h44, 32'h33, 2'b10, 32'hAA, 32'hBB, 1'b1);
    D  = mk(2'b11, 5'd9, 5'd0, 32'h66, 32'h55, 2'b11, 32'h0, 32'h0, 1'b0);
    De = mk(2'b11, 5'd9, 5'd0, 32'h66, 32'h55, 2'b10, 32'h0, 32'h0, 1'b0);
    E  = mk(2'b01, 5'd6, 5'd4, 32'h88, 32'h77, 2'b11, 32'h10, 32'h20, 1'b1);
    Ee = mk(2'b01, 5'd6, 5'd4, 32'h88, 32'h77, 2'b01, 32'h10, 32'h20, 1'b1);
    F  = mk(2'b10, 5'd8, 5'd2, 32'h99, 32'h98, 2'b11, 32'h30, 32'h40, 1'b1);
    Fe = mk(2'b10, 5'd8, 5'd2, 32'h99, 32'h98, 2'b10, 32'h30, 32'h40, 1'b0);
    H  = mk(2'b11, 5'd12, 5'd13, 32'hCAFE, 32'hBEEF, 2'b11, 32'h5, 32'h6, 1'b1);
    Ed = mk(2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 2'b11, 32'hDEAD, 32'h3, 1'b1);
    N  = mk(2'b00, 5'd4, 5'd3, 32'hAB, 32'hCD, 2'b11, 32'h7, 32'h8, 1'b1);
    Ne = mk(2'b00, 5'd4, 5'd3, 32'hAB, 32'hCD, 2'b00, 32'h7, 32'h8, 1'b0);

    // reset with random garbage on the inputs
    for (int k = 0; k < 2; k++) begin
      obs_t rnd;
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step(1, rnd.whilo, 1'b0, 1'b0, rnd, Z, 0);
    end
    step(0, 0, 0, 0, A, Ae, 2);          // two lanes, distinct addresses
    step(0, 0, 0, 0, C, Ce, 2);          // same address: lane1 wins
    step(0, 0, 0, 0, D, De, 2);          // lane0 targets $zero
    step(0, 0, 0, 0, E, Ee, 1);          // lane1 invalid
    step(0, 0, 0, 0, F, Fe, 1);          // lane0 invalid gates whilo
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, H, Fe, 0);  // hold
    step(0, 1, 0, 0, H, Z, 0);           // bubble
    step(0, 0, 0, 0, A, Ae, 2);
    step(0, 0, 0, 1, Ed, Z, 0);          // flush beats load
    step(0, 0, 0, 0, E, Ee, 1);
    step(0, 1, 1, 1, H, Z, 0);           // flush beats hold
    step(0, 0, 0, 0, A, Ae, 2);
    step(0, 1, 1, 0, H, Ae, 0);
    step(1, 1, 1, 0, H, Z, 0);           // reset mid-hold
    step(0, 0, 0, 0, N, Ne, 0);          // load with no valid lanes
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0, A, Ae, 2);  // retired -> 14
    step(0, 0, 0, 0, E, Ee, 1);          // 15
    step(0, 0, 0, 0, E, Ee, 1);          // wraps to 0
    step(0, 0, 0, 0, A, Ae, 2);          // 2

    begin
      int t = 0;
      while (sb.size() > 0 && t < 20) begin
        @(posedge clk);
        t++;
      end
      #2;
      if (sb.size() > 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
